// File: rtl/alu_pkg.sv
// Opcode constants, arbiter state encoding and NZV flag write-mask helper
// shared by the ALU arbiter and its sub-blocks.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b010;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

  // B/BR/PCS/HLT occupy the top quarter of the opcode space.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle for one ALU requester port.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
);
  logic              valid;
  logic              ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output valid, op, a, b, rsp_ready,
    input  ready, rsp_valid, rsp_data
  );

  modport slave (
    input  valid, op, a, b, rsp_ready,
    output ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer lives in the caller so the same
// block can serve other shared resources.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       ptr_nxt_o
);
  // On a tie ptr_i picks the winner; otherwise the lone requester wins.
  assign gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] |  ptr_i);

  assign ptr_nxt_o = advance_i ? gnt_o[0] : ptr_i;
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the auxiliary path
// (port 1). Optional grant counters are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave r0_if,
  alu_share_arbiter_if.slave r1_if,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_in1_o,
  output logic [DATA_W-1:0] alu_in2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [2:0]        flag_wen_o,
  output logic              busy_o,
  output logic [15:0]       perf_cnt0_o,
  output logic [15:0]       perf_cnt1_o
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;

  logic [1:0] req_valid;
  logic [1:0] gnt;
  logic       accept;
  logic       ptr_nxt;
  logic       idle;

  assign idle      = (state_q == IDLE);
  assign req_valid = {r1_if.valid, r0_if.valid};
  assign accept    = idle && (|req_valid) && !rst;
  assign busy_o    = !idle;

  rr_arb2 u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .advance_i (accept),
    .gnt_o     (gnt),
    .ptr_nxt_o (ptr_nxt)
  );

  // Masked during reset so no requester sees a phantom acceptance.
  assign r0_if.ready = idle & gnt[0] & ~rst;
  assign r1_if.ready = idle & gnt[1] & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    rr_ptr_d           = rr_ptr_q;
    op_d               = op_q;
    a_d                = a_q;
    b_d                = b_q;
    res_d              = res_q;
    alu_op_o           = '0;
    alu_in1_o          = '0;
    alu_in2_o          = '0;
    flag_wen_o         = 3'b000;
    r0_if.rsp_valid    = 1'b0;
    r0_if.rsp_data     = '0;
    r1_if.rsp_valid    = 1'b0;
    r1_if.rsp_data     = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d  = gnt[1];
          op_d     = gnt[1] ? r1_if.op : r0_if.op;
          a_d      = gnt[1] ? r1_if.a  : r0_if.a;
          b_d      = gnt[1] ? r1_if.b  : r0_if.b;
          rr_ptr_d = ptr_nxt;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        alu_op_o   = op_q;
        alu_in1_o  = a_q;
        alu_in2_o  = b_q;
        // Only the execute stage owns the architectural flags.
        flag_wen_o = owner_q ? 3'b000 : flag_mask(op_q);
        res_d      = is_ctrl_op(op_q) ? '0 : alu_result_i;
        state_d    = RESP;
      end
      RESP: begin
        if (!owner_q) begin
          r0_if.rsp_valid = 1'b1;
          r0_if.rsp_data  = res_q;
          if (r0_if.rsp_ready) state_d = IDLE;
        end else begin
          r1_if.rsp_valid = 1'b1;
          r1_if.rsp_data  = res_q;
          if (r1_if.rsp_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_ARB_PERF_EN
  logic [1:0]       grant_pulse;
  logic [1:0][15:0] perf_cnt;

  assign grant_pulse = gnt & {2{accept}};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = (grant_pulse[gi] && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign perf_cnt[gi] = cnt_q;
  end

  assign perf_cnt0_o = perf_cnt[0];
  assign perf_cnt1_o = perf_cnt[1];
`else
  assign perf_cnt0_o = '0;
  assign perf_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter; the bench also plays the ALU.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst;

  alu_share_arbiter_if #(.DATA_W(16), .OP_W(4)) r0_if ();
  alu_share_arbiter_if #(.DATA_W(16), .OP_W(4)) r1_if ();

  logic [3:0]  alu_op;
  logic [15:0] alu_in1, alu_in2, alu_result;
  logic [2:0]  flag_wen;
  logic        busy;
  logic [15:0] perf_cnt0, perf_cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(16), .OP_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_if        (r0_if),
    .r1_if        (r1_if),
    .alu_op_o     (alu_op),
    .alu_in1_o    (alu_in1),
    .alu_in2_o    (alu_in2),
    .alu_result_i (alu_result),
    .flag_wen_o   (flag_wen),
    .busy_o       (busy),
    .perf_cnt0_o  (perf_cnt0),
    .perf_cnt1_o  (perf_cnt1)
  );

  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    case (op)
      4'h0:    r = x + y;
      4'h1:    r = x - y;
      4'h2:    r = x ^ y;
      4'h3:    r = x & y;
      4'h4:    r = x << y[3:0];
      4'h5:    r = 16'($signed(x) >>> y[3:0]);
      4'h6:    r = (x >> y[3:0]) | (x << (5'd16 - {1'b0, y[3:0]}));
      4'h7:    r = x | y;
      default: r = x + ~y + 16'h5A5A;
    endcase
    return r;
  endfunction

  assign alu_result = alu_model(alu_op, alu_in1, alu_in2);

  function automatic logic [2:0] nzv_mask(input logic [3:0] op);
    case (op)
      4'h0, 4'h1:             return 3'b111;
      4'h2, 4'h4, 4'h5, 4'h6: return 3'b010;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] expected_result(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    return (op >= 4'hC) ? 16'h0000 : alu_model(op, x, y);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state, owned by the monitor.
  logic [15:0] exp_q0[$], exp_q1[$];
  int          grant_log[$];
  int          acc_cnt[2];
  int          perf_m[2];
  bit          busy_m, owner_m, rptr_m;
  logic [3:0]  op_m;
  logic [15:0] a_m, b_m;
  int          acc_n, n;

  initial begin : monitor
    bit          v0, v1, was_busy, in_exec, resp, rv0_e, rv1_e, w;
    bit   [1:0]  rdy_e;
    logic [15:0] d0_e, d1_e, hd0, hd1;
    logic [2:0]  flag_e;
    n = 0; busy_m = 0; owner_m = 0; rptr_m = 0; acc_n = 0;
    op_m = '0; a_m = '0; b_m = '0;
    acc_cnt[0] = 0; acc_cnt[1] = 0; perf_m[0] = 0; perf_m[1] = 0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        check("reset_outputs",
              {busy, flag_wen, alu_op, alu_in1, alu_in2, r0_if.rsp_valid, r0_if.rsp_data,
               r1_if.rsp_valid, r1_if.rsp_data, perf_cnt0, perf_cnt1, r0_if.ready, r1_if.ready}, 128'd0);
        busy_m = 0; rptr_m = 0;
        exp_q0.delete(); exp_q1.delete();
        perf_m[0] = 0; perf_m[1] = 0;
      end else begin
        v0 = r0_if.valid;
        v1 = r1_if.valid;
        was_busy = busy_m;
        if (busy_m)        rdy_e = 2'b00;
        else if (v0 && v1) rdy_e = rptr_m ? 2'b10 : 2'b01;
        else               rdy_e = {v1, v0};
        check("ready", {r1_if.ready, r0_if.ready}, rdy_e);
        check("busy", busy, busy_m);

        in_exec = busy_m && (n == acc_n + 1);
        flag_e  = (in_exec && !owner_m) ? nzv_mask(op_m) : 3'b000;
        check("alu_drive", {alu_op, alu_in1, alu_in2, flag_wen},
              in_exec ? {op_m, a_m, b_m, flag_e} : {36'd0, flag_e});

        resp  = busy_m && (n >= acc_n + 2);
        rv0_e = resp && !owner_m;
        rv1_e = resp && owner_m;
        hd0   = (exp_q0.size() != 0) ? exp_q0[0] : 16'h0000;
        hd1   = (exp_q1.size() != 0) ? exp_q1[0] : 16'h0000;
        d0_e  = rv0_e ? hd0 : 16'h0000;
        d1_e  = rv1_e ? hd1 : 16'h0000;
        check("rsp0", {r0_if.rsp_valid, r0_if.rsp_data}, {rv0_e, d0_e});
        check("rsp1", {r1_if.rsp_valid, r1_if.rsp_data}, {rv1_e, d1_e});

`ifdef ALU_ARB_PERF_EN
        check("perf", {perf_cnt0, perf_cnt1}, {16'(perf_m[0]), 16'(perf_m[1])});
`else
        check("perf", {perf_cnt0, perf_cnt1}, 32'd0);
`endif

        if (rv0_e && r0_if.rsp_ready && exp_q0.size() != 0) begin
          $display("txn port=0 op=%h a=%h b=%h rsp=%h", op_m, a_m, b_m, exp_q0.pop_front());
          busy_m = 0;
        end
        if (rv1_e && r1_if.rsp_ready && exp_q1.size() != 0) begin
          $display("txn port=1 op=%h a=%h b=%h rsp=%h", op_m, a_m, b_m, exp_q1.pop_front());
          busy_m = 0;
        end

        if (!was_busy && rdy_e != 2'b00) begin
          w       = rdy_e[1];
          owner_m = w;
          op_m    = w ? r1_if.op : r0_if.op;
          a_m     = w ? r1_if.a  : r0_if.a;
          b_m     = w ? r1_if.b  : r0_if.b;
          if (w) exp_q1.push_back(expected_result(op_m, a_m, b_m));
          else   exp_q0.push_back(expected_result(op_m, a_m, b_m));
          grant_log.push_back(int'(w));
          rptr_m  = !w;
          busy_m  = 1;
          acc_n   = n;
          acc_cnt[w]++;
          if (perf_m[w] < 65535) perf_m[w]++;
        end
      end
      n++;
    end
  end

  task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin
      r0_if.valid = v; r0_if.op = op; r0_if.a = a; r0_if.b = b;
    end else begin
      r1_if.valid = v; r1_if.op = op; r1_if.a = a; r1_if.b = b;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input int p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int start, waited;
    start  = acc_cnt[p];
    waited = 0;
    set_req(p, 1'b1, op, a, b);
    while (acc_cnt[p] == start && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (acc_cnt[p] == start) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: port %0d not accepted after %0d cycles, required acceptance", p, waited);
    end
    set_req(p, 1'b0, 4'h0, 16'h0, 16'h0);
  endtask

  task automatic rand_port(input int p, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(p, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit done_r;
    rst = 1'b1;
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;

    // Both ports valid across reset release: strict alternation from port 0.
    fork
      begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      begin
        @(negedge clk);
        fork
          begin for (int i = 0; i < 3; i++) issue(0, 4'h0, 16'(i), 16'h0010); end
          begin for (int i = 0; i < 3; i++) issue(1, 4'h7, 16'(i), 16'h0100); end
        join
      end
    join
    check("alternation_len", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("alternation_order", grant_log[i], i % 2);
    repeat (4) @(negedge clk);

    issue(0, 4'h0, 16'h0003, 16'h0004);
    repeat (4) @(negedge clk);
    issue(1, 4'h2, 16'h00FF, 16'h00FF);
    repeat (4) @(negedge clk);

    // Backpressure on a port-0 SUB while port 1 waits.
    r0_if.rsp_ready = 1'b0;
    issue(0, 4'h1, 16'h1234, 16'h0034);
    fork
      issue(1, 4'h0, 16'h0005, 16'h0006);
      begin
        repeat (6) @(negedge clk);
        r0_if.rsp_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    // Reset while a port-1 request is in EXEC: its result must vanish.
    issue(1, 4'h3, 16'hAAAA, 16'h5555);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    fork
      issue(0, 4'h4, 16'h0001, 16'h0003);
      issue(1, 4'h5, 16'h8000, 16'h0002);
    join
    check("post_reset_first_grant", (grant_log.size() != 0) ? grant_log[0] : -1, 0);
    repeat (4) @(negedge clk);

    issue(0, 4'hF, 16'hBEEF, 16'h1234);
    repeat (4) @(negedge clk);

    done_r = 0;
    fork
      begin
        fork
          rand_port(0, 40);
          rand_port(1, 40);
        join
        done_r = 1;
      end
      while (!done_r) begin
        @(negedge clk);
        r0_if.rsp_ready = ($urandom_range(0, 3) != 0);
        r1_if.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drained", {busy_m, 16'(exp_q0.size()), 16'(exp_q1.size())}, 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters.
  - Port 0 is the execute stage.
  - Port 1 is the address-generation / auxiliary path.
- Round-robin arbitration, valid/ready handshakes on request and response, one transaction in flight.
- Drives the ALU inputs and opcode, captures the ALU result, and generates the NZV flag write-enables.
- Sits between the decode/execute control and the ALU instance.

Parameters:
- DATA_W, 16, operand/result width.
- OP_W, 4, opcode width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- r0_valid  input  1  port 0 request valid.
- r0_ready  output  1  port 0 request accepted this cycle.
- r0_op  input  OP_W  port 0 opcode.
- r0_a  input  DATA_W  port 0 operand 1.
- r0_b  input  DATA_W  port 0 operand 2.
- r0_rsp_valid  output  1  port 0 result valid.
- r0_rsp_ready  input  1  port 0 result consumed.
- r0_rsp_data  output  DATA_W  port 0 result.
- r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_rsp_valid, r1_rsp_ready, r1_rsp_data: port 1, same widths and meanings.
- alu_op  output  OP_W  opcode to ALU.
- alu_in1  output  DATA_W  operand 1 to ALU.
- alu_in2  output  DATA_W  operand 2 to ALU.
- alu_result  input  DATA_W  ALU output.
- flag_wen  output  3  {N,Z,V} flag-register write enables.
- busy  output  1  state != IDLE.
- perf_cnt0  output  16  port 0 grant count (see Optional Feature).
- perf_cnt1  output  16  port 1 grant count (see Optional Feature).

Behaviour:
- States: IDLE, EXEC, RESP. Registered fields: owner, op_q, a_q, b_q, res_q, rr_ptr.
- IDLE:
  - Grant goes to the valid port. If both are valid, grant goes to port rr_ptr.
  - rX_ready = (state==IDLE) and granted; it is combinational from the valids and rr_ptr.
  - On valid&ready, latch op/a/b and owner, set rr_ptr = ~owner, and go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_op/alu_in1/alu_in2 = op_q/a_q/b_q.
  - At the end of the cycle, capture alu_result into res_q and go to RESP.
- flag_wen during EXEC, only when owner==0:
  - 3'b111 for ADD (0000) and SUB (0001).
  - 3'b010 for XOR (0010), SLL (0100), SRA (0101), ROR (0110).
  - 3'b000 for all other opcodes.
  - Port 1 never writes flags.
- flag_wen is 3'b000 in all other states.
- In IDLE and RESP, alu_op/in1/in2 are driven to 0.
- RESP:
  - r{owner}_rsp_valid=1 and r{owner}_rsp_data=res_q; the other port's rsp_valid=0 and rsp_data=0.
  - On rsp_valid&rsp_ready, go to IDLE.
  - The result is held indefinitely under backpressure.
- Opcodes 1100–1111 (B/BR/PCS/HLT) are accepted but res_q is forced to 0 and flag_wen to 000.
- Latency:
  - Acceptance edge at cycle t; EXEC in cycle t+1; rsp_valid from cycle t+2.
  - Peak throughput is 1 op per 3 cycles.
  - No request is accepted while in EXEC or RESP.
- Requesters hold valid and operands stable until ready; the arbiter does not re-check valid after acceptance.
- Reset, including mid-transaction:
  - state=IDLE, rr_ptr=0, all registers 0, all outputs 0.
  - The in-flight result is dropped; no rsp_valid is issued for it.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - perf_cnt0 and perf_cnt1 increment on each accepted request of their port.
  - They saturate at 16'hFFFF and clear on rst.
- Undefined: no counter logic is built; perf_cnt0 and perf_cnt1 are tied to 0.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants (OP_ADD ... OP_HLT).
  - State enum (IDLE/EXEC/RESP).
  - Flag-mask function opcode -> 3-bit NZV write mask.
- Sub-module rr_arb2: 2-input round-robin grant.
  - Inputs: req[1:0], ptr, advance.
  - Output: one-hot gnt.
  - Shared with future memory-port arbitration.

Test Plan:
- Port 0 only, ADD, a=16'h0003, b=16'h0004:
  - r0_ready the same cycle; EXEC with alu_op=0000 and flag_wen=111.
  - r0_rsp_valid 2 cycles after acceptance with data 16'h0007.
- Both valid at reset release:
  - Port 0 granted first, then port 1, then port 0 again.
  - Strict alternation over 6 back-to-back requests.
- Port 1 XOR, a=16'h00FF, b=16'h00FF:
  - rsp data 16'h0000; flag_wen remains 000 in every cycle.
- Backpressure:
  - Port 0 SUB result held, r0_rsp_ready=0 for 5 cycles: rsp_valid and data stable, r0_ready/r1_ready=0 throughout.
  - Release rsp_ready: IDLE the next cycle.
- Reset pulsed during EXEC of port 1 request:
  - No rsp_valid follows; rr_ptr=0; the next simultaneous request grants port 0.
- Port 0 opcode 1111 (HLT):
  - rsp_data 16'h0000, flag_wen 000.
  - With ALU_ARB_PERF_EN defined, perf_cnt0 increments by 1.
